// File: rtl/seq_multiplier_pkg.sv
// Shared arithmetic definitions for the sequential multiplier: FSM state codes
// and a width-generic two's complement negate helper.
package seq_multiplier_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Widest value the helper handles; callers zero-extend in and truncate out.
    localparam int MAX_W = 64;

    // Returns -x when do_neg is set, x otherwise; a correct |x| or -x after
    // truncation to any width up to MAX_W.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x,
                                                  input logic             do_neg);
        if (do_neg)
            return ~x + MAX_W'(1);
        return x;
    endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// Ripple-carry adder, N bits wide, used for the accumulate step of the multiplier.
module adderNbit #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic c;
        c    = cin;
        sum  = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, W x W -> 2W, one multiplier bit per cycle,
// signed or unsigned per operation, valid/ready on both sides.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_nxt;
    logic [2*W-1:0]   pp;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shamt;
    logic             neg;
    logic             cout_unused;
    logic signed [W-1:0] a_s;
    logic signed [W-1:0] b_s;

    assign a_s = $signed(a);
    assign b_s = $signed(b);

    // Partial product weight grows by one bit per iteration: W - cnt = 0 .. W-1.
    assign shamt = CNT_W'(W) - cnt;
    assign pp    = mplier[0] ? ({{W{1'b0}}, mcand} << shamt) : '0;

    adderNbit #(.N(2 * W)) u_acc_add (
        .a    (acc),
        .b    (pp),
        .cin  (1'b0),
        .sum  (acc_nxt),
        .cout (cout_unused)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Magnitudes are multiplied unsigned; the sign is reapplied at the end.
                        mcand  <= W'(cond_neg(MAX_W'(a), is_signed & a_s[W-1]));
                        mplier <= W'(cond_neg(MAX_W'(b), is_signed & b_s[W-1]));
                        neg    <= is_signed & (a_s[W-1] ^ b_s[W-1]);
                        acc    <= '0;
                        cnt    <= CNT_W'(W);
                    end
                end
                S_RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        p         <= (2 * W)'(cond_neg(MAX_W'(acc_nxt), neg));
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

endmodule
